// File: rtl/m68k_bus_master.sv
// m68k_bus_master: single-transfer 68000-style asynchronous bus master with DTACK timeout
//   CLK, RST (sync, active-low)                 clock and reset
//   REQ, REQ_RW, REQ_ADDR, REQ_BE, REQ_WDATA    host request, sampled only while idle
//   BUSY, DONE, ERR, RDATA                      host status; ERR valid with DONE
//   ADDR_OUT, AS, UDS, LDS, RW                  bus address and active-low strobes
//   DATA_OUT, DATA_OE, DATA_IN                  bus data path
//   DTACK                                       asynchronous active-low acknowledge
module m68k_bus_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        REQ_RW,
    input  logic [22:0] REQ_ADDR,
    input  logic [1:0]  REQ_BE,
    input  logic [15:0] REQ_WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] RDATA,
    output logic [22:0] ADDR_OUT,
    output logic        AS,
    output logic        UDS,
    output logic        LDS,
    output logic        RW,
    output logic [15:0] DATA_OUT,
    output logic        DATA_OE,
    input  logic [15:0] DATA_IN,
    input  logic        DTACK
);
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_DS = 3'd2, S_WAIT = 3'd3,
                           S_LATCH = 3'd4, S_END = 3'd5, S_RECOV = 3'd6;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic [1:0]    sync_q, be_q, be_d;
    logic          err_q, err_d, busy_q, busy_d, done_q, done_d, erro_q, erro_d;
    logic          as_q, as_d, uds_q, uds_d, lds_q, lds_d, rw_q, rw_d, oe_q, oe_d;
    logic [15:0]   rdata_q, rdata_d, dout_q, dout_d;
    logic [22:0]   addr_q, addr_d;
    logic          dtack_s;
    assign dtack_s   = sync_q[1];
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        be_d    = be_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        erro_d  = 1'b0;
        as_d    = as_q;
        uds_d   = uds_q;
        lds_d   = lds_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        rdata_d = rdata_q;
        dout_d  = dout_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: if (REQ) begin
                if (REQ_BE == 2'b00) begin
                    // nothing to strobe: reject without touching the bus
                    done_d = 1'b1;
                    erro_d = 1'b1;
                end else begin
                    addr_d  = REQ_ADDR;
                    rw_d    = REQ_RW;
                    dout_d  = REQ_WDATA;
                    oe_d    = ~REQ_RW;
                    be_d    = REQ_BE;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                as_d = 1'b0;
                if (rw_q) {uds_d, lds_d} = ~be_q;
                state_d = S_DS;
            end
            S_DS: begin
                // writes delay the data strobes a cycle so data is stable first
                if (!rw_q) {uds_d, lds_d} = ~be_q;
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!dtack_s) state_d = S_LATCH;
                else if (timer_q == T_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_END;
                end else timer_d = timer_inc;
            end
            S_LATCH: begin
                if (rw_q) rdata_d = DATA_IN;
                state_d = S_END;
            end
            S_END: begin
                {as_d, uds_d, lds_d} = 3'b111;
                timer_d = '0;
                oe_d    = 1'b0;
                rw_d    = 1'b1;
                state_d = S_RECOV;
            end
            S_RECOV: begin
                // wait for the slave to release DTACK, bounded by the same timeout
                if (dtack_s || timer_q == T_LAST) begin
                    done_d  = 1'b1;
                    erro_d  = err_q | ~dtack_s;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else timer_d = timer_inc;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            sync_q  <= 2'b11;
            be_q    <= 2'b00;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            erro_q  <= 1'b0;
            as_q    <= 1'b1;
            uds_q   <= 1'b1;
            lds_q   <= 1'b1;
            rw_q    <= 1'b1;
            oe_q    <= 1'b0;
            rdata_q <= '0;
            dout_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sync_q  <= {sync_q[0], DTACK};
            be_q    <= be_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            erro_q  <= erro_d;
            as_q    <= as_d;
            uds_q   <= uds_d;
            lds_q   <= lds_d;
            rw_q    <= rw_d;
            oe_q    <= oe_d;
            rdata_q <= rdata_d;
            dout_q  <= dout_d;
            addr_q  <= addr_d;
        end
    end
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = erro_q;
    assign RDATA    = rdata_q;
    assign ADDR_OUT = addr_q;
    assign AS       = as_q;
    assign UDS      = uds_q;
    assign LDS      = lds_q;
    assign RW       = rw_q;
    assign DATA_OUT = dout_q;
    assign DATA_OE  = oe_q;
endmodule

// File: tb/tb_m68k_bus_master.sv
// tb_m68k_bus_master: directed and randomized checks of m68k_bus_master against a timing model
module tb_m68k_bus_master;
    localparam int T = 16;
    logic        CLK = 1'b0, RST, REQ, REQ_RW, BUSY, DONE, ERR, AS, UDS, LDS, RW, DATA_OE, DTACK;
    logic [22:0] REQ_ADDR, ADDR_OUT;
    logic [1:0]  REQ_BE;
    logic [15:0] REQ_WDATA, RDATA, DATA_OUT, DATA_IN;
    int          checks = 0, errors = 0;
    logic [15:0] exp_rdata;
    int          o_done_edge, o_as_fall, o_as_rise, o_uds_fall, o_lds_fall;
    logic        o_err, o_oe_bad, o_addr_bad, o_wdata_bad, o_rw_bad, o_busy_at_done, o_oe_at_done;
    m68k_bus_master #(.TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_RW(REQ_RW), .REQ_ADDR(REQ_ADDR), .REQ_BE(REQ_BE),
        .REQ_WDATA(REQ_WDATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
        .ADDR_OUT(ADDR_OUT), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .DATA_OUT(DATA_OUT),
        .DATA_OE(DATA_OE), .DATA_IN(DATA_IN), .DTACK(DTACK)
    );
    always #5 CLK = ~CLK;
    // Issues one request and plays the slave. Edge n is the n-th rising edge after the
    // request is presented (edge 1 = accept); observations are taken at the following falling edge.
    // mode 0: DTACK low dly cycles after AS seen low, released when AS seen high
    // mode 1: never acknowledge; mode 2: DTACK stuck low dly cycles after AS falls
    // mode 3: DTACK already low before accept, released after edge 3
    task automatic run_txn(input logic rw, input logic [22:0] addr, input logic [1:0] be,
                           input logic [15:0] wd, input logic [15:0] din, input int dly,
                           input int mode, input int pulse_at);
        @(negedge CLK);
        REQ = 1'b1; REQ_RW = rw; REQ_ADDR = addr; REQ_BE = be; REQ_WDATA = wd;
        DATA_IN = din; DTACK = (mode == 3) ? 1'b0 : 1'b1;
        o_done_edge = -1; o_as_fall = -1; o_as_rise = -1; o_uds_fall = -1; o_lds_fall = -1;
        o_err = 1'bx; o_oe_bad = 1'b0; o_addr_bad = 1'b0; o_wdata_bad = 1'b0; o_rw_bad = 1'b0;
        o_busy_at_done = 1'bx; o_oe_at_done = 1'bx;
        for (int n = 1; n <= 300; n++) begin
            @(negedge CLK);
            if (n == 1) REQ = 1'b0;
            if (n == pulse_at) begin
                REQ = 1'b1; REQ_RW = ~rw; REQ_ADDR = ~addr; REQ_BE = 2'b11;
            end else if (n == pulse_at + 1) REQ = 1'b0;
            if (!AS && o_as_fall < 0) o_as_fall = n;
            if (AS && o_as_fall >= 0 && o_as_rise < 0) o_as_rise = n;
            if (!UDS && o_uds_fall < 0) o_uds_fall = n;
            if (!LDS && o_lds_fall < 0) o_lds_fall = n;
            if (rw ? DATA_OE : ((!UDS || !LDS) && !DATA_OE)) o_oe_bad = 1'b1;
            if (!AS && ADDR_OUT !== addr) o_addr_bad = 1'b1;
            if (!AS && RW !== rw) o_rw_bad = 1'b1;
            if (!rw && DATA_OE && DATA_OUT !== wd) o_wdata_bad = 1'b1;
            if (DONE) begin
                o_done_edge = n; o_err = ERR; o_busy_at_done = BUSY; o_oe_at_done = DATA_OE;
                break;
            end
            case (mode)
                0: if (o_as_fall >= 0 && AS) DTACK = 1'b1;
                   else if (o_as_fall >= 0 && n >= o_as_fall + dly) DTACK = 1'b0;
                2: if (o_as_fall >= 0 && n >= o_as_fall + dly) DTACK = 1'b0;
                3: if (n >= 3) DTACK = 1'b1;
                default: DTACK = 1'b1;
            endcase
        end
        REQ = 1'b0;
        if (mode != 2) DTACK = 1'b1;
    endtask
    task automatic test_reset;
        RST = 1'b0; REQ = 1'b0; REQ_RW = 1'b1; REQ_ADDR = '0; REQ_BE = '0; REQ_WDATA = '0;
        DATA_IN = '0; DTACK = 1'b1;
        repeat (3) @(negedge CLK);
        checks++; if ({AS, UDS, LDS, RW, DATA_OE, BUSY, DONE, ERR} !== 8'b1111_0000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 11110000", {AS, UDS, LDS, RW, DATA_OE, BUSY, DONE, ERR});
        end
        checks++; if ({RDATA, ADDR_OUT, DATA_OUT} !== 55'd0) begin
            errors++; $display("FAIL reset_data: rdata %h addr %h dout %h want 0", RDATA, ADDR_OUT, DATA_OUT);
        end
        RST = 1'b1; exp_rdata = 16'h0;
        repeat (3) @(negedge CLK);
    endtask
    task automatic test_read;
        run_txn(1'b1, 23'h012345, 2'b11, 16'h0, 16'hBEEF, 2, 0, -1);
        exp_rdata = 16'hBEEF;
        checks++; if (o_done_edge !== 12) begin errors++; $display("FAIL read_done_edge: got %0d want 12", o_done_edge); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL read_err: got %b want 0", o_err); end
        checks++; if (RDATA !== 16'hBEEF) begin errors++; $display("FAIL read_rdata: got %h want beef", RDATA); end
        checks++; if (o_as_fall !== 2 || o_uds_fall !== 2 || o_lds_fall !== 2) begin
            errors++; $display("FAIL read_strobes: as %0d uds %0d lds %0d want 2 2 2", o_as_fall, o_uds_fall, o_lds_fall);
        end
        checks++; if ({o_addr_bad, o_oe_bad, o_rw_bad} !== 3'b000) begin
            errors++; $display("FAIL read_bus: addr/oe/rw bad %b want 000", {o_addr_bad, o_oe_bad, o_rw_bad});
        end
    endtask
    task automatic test_write;
        run_txn(1'b0, 23'h7A0F0F, 2'b01, 16'hA55A, 16'h1111, 2, 0, -1);
        checks++; if (o_lds_fall !== o_as_fall + 1 || o_uds_fall !== -1) begin
            errors++; $display("FAIL write_strobes: as %0d lds %0d uds %0d want lds=as+1 uds=-1", o_as_fall, o_lds_fall, o_uds_fall);
        end
        checks++; if ({o_oe_bad, o_wdata_bad, o_addr_bad, o_rw_bad} !== 4'b0000) begin
            errors++; $display("FAIL write_bus: oe/wdata/addr/rw bad %b want 0000", {o_oe_bad, o_wdata_bad, o_addr_bad, o_rw_bad});
        end
        checks++; if (o_done_edge !== 12 || o_err !== 1'b0) begin
            errors++; $display("FAIL write_done: edge %0d err %b want 12 0", o_done_edge, o_err);
        end
        checks++; if (RDATA !== exp_rdata || o_oe_at_done !== 1'b0) begin
            errors++; $display("FAIL write_after: rdata %h oe %b want %h 0", RDATA, o_oe_at_done, exp_rdata);
        end
    endtask
    task automatic test_min_latency;
        run_txn(1'b1, 23'h000100, 2'b11, 16'h0, 16'h3C5A, 0, 3, -1);
        exp_rdata = 16'h3C5A;
        checks++; if (o_done_edge !== 7 || o_err !== 1'b0 || RDATA !== exp_rdata) begin
            errors++; $display("FAIL min_latency: edge %0d err %b rdata %h want 7 0 %h", o_done_edge, o_err, RDATA, exp_rdata);
        end
    endtask
    task automatic test_timeout;
        run_txn(1'b1, 23'h2AAAAA, 2'b11, 16'h0, 16'h1234, 0, 1, -1);
        // AS falls at edge 2, WAIT spans edges 4..3+T, strobes negate at 4+T, DONE one edge later
        checks++; if (o_as_rise !== 4 + T) begin errors++; $display("FAIL timeout_as_rise: got %0d want %0d", o_as_rise, 4 + T); end
        checks++; if (o_done_edge !== 5 + T || o_err !== 1'b1) begin
            errors++; $display("FAIL timeout_done: edge %0d err %b want %0d 1", o_done_edge, o_err, 5 + T);
        end
        checks++; if (RDATA !== exp_rdata) begin errors++; $display("FAIL timeout_rdata: got %h want %h", RDATA, exp_rdata); end
    endtask
    task automatic test_recov_timeout;
        run_txn(1'b0, 23'h001234, 2'b10, 16'h5EED, 16'h0, 2, 2, -1);
        // seen at edge 7, strobes up at 9, then T RECOV cycles with DTACK low
        checks++; if (o_as_rise !== 9 || o_done_edge !== 9 + T || o_err !== 1'b1) begin
            errors++; $display("FAIL recov_timeout: rise %0d edge %0d err %b want 9 %0d 1", o_as_rise, o_done_edge, o_err, 9 + T);
        end
        checks++; if (o_busy_at_done !== 1'b0 || RDATA !== exp_rdata) begin
            errors++; $display("FAIL recov_state: busy %b rdata %h want 0 %h", o_busy_at_done, RDATA, exp_rdata);
        end
        DTACK = 1'b1;
        repeat (3) @(negedge CLK);
        run_txn(1'b1, 23'h004321, 2'b11, 16'h0, 16'h6789, 1, 0, -1);
        exp_rdata = 16'h6789;
        checks++; if (o_done_edge !== 11 || o_err !== 1'b0 || RDATA !== exp_rdata) begin
            errors++; $display("FAIL recov_next: edge %0d err %b rdata %h want 11 0 %h", o_done_edge, o_err, RDATA, exp_rdata);
        end
    endtask
    task automatic test_be_zero;
        logic bad;
        @(negedge CLK);
        REQ = 1'b1; REQ_RW = 1'b1; REQ_BE = 2'b00; REQ_ADDR = 23'h1; DTACK = 1'b1;
        @(negedge CLK);
        REQ = 1'b0;
        checks++; if ({DONE, ERR, BUSY, AS} !== 4'b1101) begin
            errors++; $display("FAIL be_zero_done: done/err/busy/as %b want 1101", {DONE, ERR, BUSY, AS});
        end
        bad = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            if (DONE || BUSY || !AS || !UDS || !LDS) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL be_zero_quiet: activity %b want 0", bad); end
    endtask
    task automatic test_busy_ignore;
        logic bad;
        run_txn(1'b0, 23'h055555, 2'b11, 16'hF00D, 16'h0, 3, 0, 4);
        checks++; if ({o_addr_bad, o_rw_bad, o_wdata_bad} !== 3'b000 || o_done_edge !== 13 || o_err !== 1'b0) begin
            errors++; $display("FAIL busy_ignore_txn: bad %b edge %0d err %b want 000 13 0", {o_addr_bad, o_rw_bad, o_wdata_bad}, o_done_edge, o_err);
        end
        bad = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (BUSY || !AS) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL busy_ignore_queue: activity %b want 0", bad); end
    endtask
    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            logic        rw;
            logic [1:0]  be;
            logic [15:0] din;
            int          dly, seen, exp_uds, exp_lds;
            logic        exp_err;
            rw  = 1'($urandom);
            be  = 2'($urandom_range(1, 3));
            din = 16'($urandom);
            dly = $urandom_range(0, 20);
            // AS falls at edge 2; DTACK driven after edge 2+dly is seen 3 edges later through the
            // synchronizer; the acknowledge window closes at edge 3+T
            seen    = 2 + dly + 3;
            exp_err = (seen > 3 + T);
            exp_uds = be[1] ? (rw ? 2 : 3) : -1;
            exp_lds = be[0] ? (rw ? 2 : 3) : -1;
            run_txn(rw, 23'($urandom), be, 16'($urandom), din, dly, 0, -1);
            if (rw && !exp_err) exp_rdata = din;
            checks++; if (o_done_edge < 0 || o_err !== exp_err) begin
                errors++; $display("FAIL rand%0d_err: edge %0d err %b want done err %b (dly %0d)", i, o_done_edge, o_err, exp_err, dly);
            end
            checks++; if (RDATA !== exp_rdata) begin errors++; $display("FAIL rand%0d_rdata: got %h want %h", i, RDATA, exp_rdata); end
            checks++; if (o_uds_fall !== exp_uds || o_lds_fall !== exp_lds || o_oe_bad) begin
                errors++; $display("FAIL rand%0d_strobes: uds %0d lds %0d oe_bad %b want %0d %0d 0", i, o_uds_fall, o_lds_fall, o_oe_bad, exp_uds, exp_lds);
            end
            // on success: latch, end (AS up), then the released DTACK takes 3 edges to be seen
            if (!exp_err) begin
                checks++; if (o_done_edge !== seen + 5) begin
                    errors++; $display("FAIL rand%0d_latency: got %0d want %0d", i, o_done_edge, seen + 5);
                end
            end
            @(negedge CLK);
        end
    endtask
    task automatic test_reset_mid;
        logic bad;
        @(negedge CLK);
        REQ = 1'b1; REQ_RW = 1'b1; REQ_BE = 2'b11; REQ_ADDR = 23'h3FFFFF; DTACK = 1'b1;
        @(negedge CLK);
        REQ = 1'b0;
        repeat (4) @(negedge CLK);
        checks++; if ({AS, BUSY} !== 2'b01) begin errors++; $display("FAIL reset_mid_pre: as/busy %b want 01", {AS, BUSY}); end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if ({AS, UDS, LDS, BUSY, DONE} !== 5'b11100 || RDATA !== 16'h0) begin
            errors++; $display("FAIL reset_mid_abort: as/uds/lds/busy/done %b rdata %h want 11100 0000", {AS, UDS, LDS, BUSY, DONE}, RDATA);
        end
        RST = 1'b1;
        bad = 1'b0;
        repeat (25) begin
            @(negedge CLK);
            if (DONE || !AS || BUSY) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL reset_mid_quiet: activity %b want 0", bad); end
    endtask
    initial begin
        test_reset;
        test_read;
        test_write;
        test_min_latency;
        test_timeout;
        test_recov_timeout;
        test_be_zero;
        test_busy_ignore;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/m68k_bus_master.md
M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the max CLK cycles spent waiting for DTACK to assert, or to negate, before a bus cycle is aborted with error.
REQ-002 The block SHALL have ports, one per line: name, direction, width, meaning.
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  reset; synchronous, active-low.
- REQ  in  1  host request; sampled only while BUSY=0.
- REQ_RW  in  1  1=read, 0=write.
- REQ_ADDR  in  23  word address [23:1].
- REQ_BE  in  2  byte enables; [1]=upper (UDS), [0]=lower (LDS); 1=enabled.
- REQ_WDATA  in  16  write data.
- BUSY  out  1  transaction in progress.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  error flag; valid only while DONE=1.
- RDATA  out  16  read data; valid from DONE until the next read completes.
- ADDR_OUT  out  23  bus address.
- AS  out  1  address strobe, active-low.
- UDS  out  1  upper data strobe, active-low.
- LDS  out  1  lower data strobe, active-low.
- RW  out  1  bus direction; 1=read.
- DATA_OUT  out  16  bus write data.
- DATA_OE  out  1  drive enable for DATA_OUT.
- DATA_IN  in  16  bus read data.
- DTACK  in  1  asynchronous acknowledge, active-low.

Function
REQ-003 DTACK SHALL pass through a 2-flop synchronizer (both flops reset to 1); every reference to dtack_s below means the synchronizer output.
REQ-004 All outputs SHALL be registered.
REQ-005 The FSM SHALL have states IDLE, ADDR, DS, WAIT, LATCH, END, RECOV.
REQ-006 IDLE, on REQ=1: latch ADDR_OUT, RW and DATA_OUT; set DATA_OE=~REQ_RW and BUSY=1; go to ADDR.
REQ-007 IDLE, on REQ=1 with REQ_BE=00: make no bus activity; pulse DONE=1, ERR=1 on the next edge; stay in IDLE.
REQ-008 ADDR: AS<=0; on a read, UDS/LDS<=~REQ_BE (latched at accept); go to DS.
REQ-009 DS: on a write, UDS/LDS<=~BE; clear the timer; go to WAIT.
REQ-010 WAIT: on dtack_s=0, go to LATCH.
REQ-011 WAIT, otherwise: if timer==TIMEOUT_CYCLES-1, set the error flag and go to END; else increment the timer.
REQ-012 LATCH: on a read, RDATA<=DATA_IN; go to END.
REQ-013 END: AS=UDS=LDS<=1; clear the timer; go to RECOV.
REQ-014 RECOV: DATA_OE<=0 and RW<=1 on entry.
REQ-015 RECOV: on dtack_s=1, pulse DONE with ERR=error flag, set BUSY<=0, go to IDLE.
REQ-016 RECOV: if dtack_s stays 0 for TIMEOUT_CYCLES cycles, set the error flag and complete as in REQ-015.
REQ-017 RDATA SHALL NOT change on writes or on timed-out reads.
REQ-018 REQ while BUSY=1 SHALL be ignored: no queueing, no effect.
REQ-019 Minimum transaction, with DTACK already low at AS fall and high by RECOV, SHALL take 7 edges from accept to DONE.
REQ-020 DATA_OE SHALL remain 1 from accept until RECOV for writes and SHALL never be 1 for reads.
REQ-021 The timer SHALL be 8 bits wide minimum, sized by ceil(log2(TIMEOUT_CYCLES+1)), and SHALL saturate rather than wrap.

Reset
REQ-022 On RST=0 at an edge, the block SHALL set state=IDLE; AS=UDS=LDS=1; RW=1; DATA_OE=0; BUSY=0; DONE=0; ERR=0; RDATA=0; ADDR_OUT=0; DATA_OUT=0; timer=0; synchronizer=11.
REQ-023 Reset asserted mid-transaction SHALL abort it with strobes negated on that edge and no DONE pulse.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Read, BE=11, addr 0x012345, responder drives DTACK low 2 cycles after AS falls with DATA_IN=0xBEEF -> UDS=LDS=0 with AS; DONE=1, ERR=0, RDATA=0xBEEF.
- Write, BE=01, WDATA=0xA55A -> LDS falls one cycle after AS, UDS stays 1; DATA_OE=1 while LDS low; DONE, ERR=0; RDATA unchanged.
- No DTACK, TIMEOUT_CYCLES=16 -> strobes negate after 16 WAIT cycles; DONE with ERR=1; RDATA unchanged.
- DTACK stuck low after a cycle -> RECOV times out; DONE with ERR=1; the next request proceeds normally once DTACK is released.
- REQ with BE=00 -> no AS activity; DONE+ERR on the next edge; REQ pulsed during BUSY -> ignored.
- RST=0 in WAIT -> AS/UDS/LDS=1, BUSY=0 next edge; no DONE.
